uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 91 +++++++++
 tb/tb_uart_rx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO behind a uart_receiver.
//   Stores each received byte together with its framing-error flag and
//   presents the oldest entry first-word fall-through.
// Ports:
//   i_CLK, i_RESET_N        clock, async active-low reset
//   i_RX_DONE/i_DATA/i_FRAMING_ERROR   write strobe, byte, error flag
//   i_READ                  pop head entry (ignored while empty)
//   i_CLEAR_OVERRUN         clears sticky o_OVERRUN (a new overrun wins)
//   o_DATA/o_DATA_ERROR     head entry, zero while empty
//   o_VALID/o_FULL/o_COUNT  occupancy status
//   o_OVERRUN               sticky: a byte was lost to a full FIFO
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int DROP_ERRORS = 0
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET_N,
  input  logic                       i_RX_DONE,
  input  logic [7:0]                 i_DATA,
  input  logic                       i_FRAMING_ERROR,
  input  logic                       i_READ,
  input  logic                       i_CLEAR_OVERRUN,
  output logic [7:0]                 o_DATA,
  output logic                       o_DATA_ERROR,
  output logic                       o_VALID,
  output logic                       o_FULL,
  output logic [$clog2(DEPTH):0]     o_COUNT,
  output logic                       o_OVERRUN
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  // Goes high on the first edge after reset release; blocks any push/pop
  // on the edge that coincides with deassertion.
  logic          run_q, run_d;

  logic push_req, push, pop, ovf, full, valid;
  logic [8:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_req  = run_q && i_RX_DONE && !((DROP_ERRORS != 0) && i_FRAMING_ERROR);
    pop       = run_q && i_READ && valid;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is ok.
    push      = push_req && (!full || pop);
    ovf       = push_req && full && !pop;
    run_d     = 1'b1;
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    overrun_d = overrun_q;
    if (i_CLEAR_OVERRUN) overrun_d = 1'b0;
    if (ovf)             overrun_d = 1'b1;
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      run_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; the empty-gating on the outputs hides stale data.
  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q] <= {i_FRAMING_ERROR, i_DATA};
  end

  assign o_DATA       = valid ? head[7:0] : 8'h00;
  assign o_DATA_ERROR = valid ? head[8]   : 1'b0;
  assign o_VALID      = valid;
  assign o_FULL       = full;
  assign o_COUNT      = count_q;
  assign o_OVERRUN    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: DROP_ERRORS=0, scoreboarded
  logic       rx0 = 0, fe0 = 0, rd0 = 0, clr0 = 0;
  logic [7:0] di0 = 0;
  logic [7:0] do0;
  logic       de0, v0, f0, ov0;
  logic [4:0] c0;
  // DUT 1: DROP_ERRORS=1, directly checked
  logic       rx1 = 0, fe1 = 0, rd1 = 0, clr1 = 0;
  logic [7:0] di1 = 0;
  logic [7:0] do1;
  logic       de1, v1, f1, ov1;
  logic [4:0] c1;

  uart_rx_fifo #(.DEPTH(16), .DROP_ERRORS(0)) dut0 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_RX_DONE(rx0), .i_DATA(di0),
    .i_FRAMING_ERROR(fe0), .i_READ(rd0), .i_CLEAR_OVERRUN(clr0),
    .o_DATA(do0), .o_DATA_ERROR(de0), .o_VALID(v0), .o_FULL(f0),
    .o_COUNT(c0), .o_OVERRUN(ov0));

  uart_rx_fifo #(.DEPTH(16), .DROP_ERRORS(1)) dut1 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_RX_DONE(rx1), .i_DATA(di1),
    .i_FRAMING_ERROR(fe1), .i_READ(rd1), .i_CLEAR_OVERRUN(clr1),
    .o_DATA(do1), .o_DATA_ERROR(de1), .o_VALID(v1), .o_FULL(f1),
    .o_COUNT(c1), .o_OVERRUN(ov1));

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop of dut0 is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd0 && v0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got %0h expected none", {de0, do0});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({de0, do0} != e) begin
          miscompares++;
          $display("FAIL pop_data: got %0h expected %0h", {de0, do0}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // store=1 means the bench expects this byte to be kept
  task automatic push0(input logic [7:0] d, input logic e, input bit store);
    rx0 = 1; di0 = d; fe0 = e;
    if (store) exp_q.push_back({e, d});
    tick();
    rx0 = 0; fe0 = 0;
  endtask

  task automatic pop0();
    rd0 = 1; tick(); rd0 = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", c0, 0); chk("rst_valid", v0, 0); chk("rst_full", f0, 0);
    chk("rst_ovr", ov0, 0);  chk("rst_data", do0, 0);
    tick(); rst_n = 1; tick(); tick();

    // single push, FWFT
    push0(8'hA5, 0, 1);
    chk("a5_valid", v0, 1); chk("a5_data", do0, 8'hA5);
    chk("a5_err", de0, 0);  chk("a5_count", c0, 1);
    pop0();
    chk("a5_empty_after", v0, 0);

    // read while empty ignored
    pop0();
    chk("empty_read_count", c0, 0);

    // fill to full, overrun byte dropped
    for (int i = 0; i < 16; i++) push0(8'(i), 0, 1);
    chk("fill_full_pre_ovr", f0, 1); chk("fill_ovr_pre", ov0, 0);
    push0(8'hFF, 0, 0);
    chk("ovr_full", f0, 1); chk("ovr_flag", ov0, 1); chk("ovr_count", c0, 16);
    for (int i = 0; i < 16; i++) pop0();
    chk("drain_count", c0, 0); chk("drain_data", do0, 0); chk("drain_valid", v0, 0);

    clr0 = 1; tick(); clr0 = 0;
    chk("clear_ovr", ov0, 0);

    // push+pop at full
    for (int i = 0; i < 16; i++) push0(8'h40 + 8'(i), 0, 1);
    rx0 = 1; di0 = 8'h3C; rd0 = 1; exp_q.push_back({1'b0, 8'h3C});
    tick(); rx0 = 0; rd0 = 0;
    chk("pp_full_count", c0, 16); chk("pp_full_ovr", ov0, 0); chk("pp_full_flag", f0, 1);
    chk("pp_head", do0, 8'h41);
    for (int i = 0; i < 16; i++) pop0();
    chk("pp_drain", c0, 0);

    // overrun with clear in same cycle: set wins
    for (int i = 0; i < 16; i++) push0(8'h80 + 8'(i), i[0], 1);
    rx0 = 1; di0 = 8'hEE; clr0 = 1;
    tick(); rx0 = 0; clr0 = 0;
    chk("ovr_set_wins", ov0, 1); chk("ovr_clr_count", c0, 16);
    clr0 = 1; tick(); clr0 = 0;
    chk("ovr_clear_alone", ov0, 0);
    for (int i = 0; i < 16; i++) pop0();

    // framing error stored when DROP_ERRORS=0
    push0(8'h11, 1, 1);
    chk("fe_stored_data", do0, 8'h11); chk("fe_stored_err", de0, 1);
    pop0();

    // DROP_ERRORS=1 discards errored byte without overrun
    rx1 = 1; di1 = 8'h11; fe1 = 1; tick();
    di1 = 8'h22; fe1 = 0; tick(); rx1 = 0;
    chk("drop_count", c1, 1); chk("drop_data", do1, 8'h22);
    chk("drop_err", de1, 0); chk("drop_ovr", ov1, 0);
    rd1 = 1; tick(); rd1 = 0;
    chk("drop_drained", v1, 0);

    // mid-operation async reset
    for (int i = 0; i < 5; i++) push0(8'hC0 + 8'(i), 0, 1);
    chk("pre_rst_count", c0, 5);
    rst_n = 0; exp_q.delete();
    #2;
    chk("arst_count", c0, 0); chk("arst_valid", v0, 0); chk("arst_data", do0, 0);
    chk("arst_err", de0, 0);  chk("arst_full", f0, 0);
    #1 rst_n = 1;
    tick(); tick();
    push0(8'h5A, 1, 1);
    chk("post_rst_count", c0, 1); chk("post_rst_data", do0, 8'h5A);
    chk("post_rst_err", de0, 1);
    pop0();

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
